// File: rtl/temp_monitor_pkg.sv
// Shared temperature-state codes and default tuning for the temperature monitor.
// The buzzer controller imports the same state codes.
package temp_monitor_pkg;

  localparam logic [1:0] ST_FRIO   = 2'd0;
  localparam logic [1:0] ST_NORMAL = 2'd1;
  localparam logic [1:0] ST_QUENTE = 2'd2;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_COLD_TH     = 18;
  localparam int unsigned DEF_HOT_TH      = 30;
  localparam int unsigned DEF_HYST        = 2;
  localparam int unsigned DEF_PERSIST     = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 100_000_000;

endpackage

// File: rtl/temp_candidate_cmp.sv
// Combinational hysteresis comparator: maps a sample and the committed state to the
// state that sample argues for.
module temp_candidate_cmp
  import temp_monitor_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned COLD_TH = DEF_COLD_TH,
  parameter int unsigned HOT_TH  = DEF_HOT_TH,
  parameter int unsigned HYST    = DEF_HYST
) (
  input  logic [WIDTH-1:0] temp_data,
  input  logic [1:0]       estado,
  output logic [1:0]       candidate
);

  localparam int unsigned W1 = WIDTH + 1;

  // One extra bit so COLD_TH+HYST never wraps.
  logic [W1-1:0] temp_ext;
  logic [W1-1:0] cold_lvl;
  logic [W1-1:0] cold_exit;
  logic [W1-1:0] hot_lvl;
  logic [W1-1:0] hot_exit;
  logic          is_cold;
  logic          is_hot;

  assign temp_ext  = {1'b0, temp_data};
  assign cold_lvl  = W1'(COLD_TH);
  assign cold_exit = W1'(COLD_TH + HYST);
  assign hot_lvl   = W1'(HOT_TH);
  assign hot_exit  = W1'(HOT_TH - HYST);
  assign is_cold   = temp_ext < cold_lvl;
  assign is_hot    = temp_ext > hot_lvl;

  always_comb begin
    candidate = ST_NORMAL;
    case (estado)
      ST_FRIO: begin
        if (temp_ext >= cold_exit) candidate = is_hot ? ST_QUENTE : ST_NORMAL;
        else                       candidate = ST_FRIO;
      end
      ST_QUENTE: begin
        if (temp_ext <= hot_exit) candidate = is_cold ? ST_FRIO : ST_NORMAL;
        else                      candidate = ST_QUENTE;
      end
      default: begin
        if (is_cold)     candidate = ST_FRIO;
        else if (is_hot) candidate = ST_QUENTE;
        else             candidate = ST_NORMAL;
      end
    endcase
  end

endmodule

// File: rtl/temp_state_classifier.sv
// Temperature-state classifier: hysteresis comparator, persistence filter and sample
// timeout watchdog driving the 2-bit estado code for the buzzer controller.
module temp_state_classifier
  import temp_monitor_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned COLD_TH     = DEF_COLD_TH,
  parameter int unsigned HOT_TH      = DEF_HOT_TH,
  parameter int unsigned HYST        = DEF_HYST,
  parameter int unsigned PERSIST     = DEF_PERSIST,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             temp_valid,
  input  logic [WIDTH-1:0] temp_data,
  output logic [1:0]       estado,
  output logic             state_changed,
  output logic             sensor_fault
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned PW = $clog2(PERSIST + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

  if (COLD_TH + HYST > HOT_TH) begin : g_bad_band
    $error("COLD_TH+HYST must not exceed HOT_TH");
  end
  if (HOT_TH < HYST) begin : g_bad_hyst
    $error("HOT_TH must be at least HYST");
  end
  if (PERSIST < 1) begin : g_bad_persist
    $error("PERSIST must be at least 1");
  end

  logic [1:0]    estado_q, estado_d;
  logic [1:0]    pending_q, pending_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          changed_q, changed_d;
  logic          fault_q, fault_d;
  logic [1:0]    candidate;
  logic [PW-1:0] run_len;

  temp_candidate_cmp #(
    .WIDTH  (WIDTH),
    .COLD_TH(COLD_TH),
    .HOT_TH (HOT_TH),
    .HYST   (HYST)
  ) u_cmp (
    .temp_data(temp_data),
    .estado   (estado_q),
    .candidate(candidate)
  );

  always_comb begin
    estado_d  = estado_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    changed_d = 1'b0;
    fault_d   = fault_q;
    // A new disagreeing candidate starts its own run at 1.
    run_len   = (candidate == pending_q) ? cnt_q + PW'(1) : PW'(1);

    if (temp_valid) begin
      fault_d = 1'b0;
      tcnt_d  = '0;
      if (candidate == estado_q) begin
        cnt_d = '0;
      end else begin
        pending_d = candidate;
        if (run_len == PW'(PERSIST)) begin
          estado_d  = candidate;
          cnt_d     = '0;
          changed_d = 1'b1;
        end else begin
          cnt_d = run_len;
        end
      end
    end else if (tcnt_q != TMAX) begin
      tcnt_d = tcnt_q + TW'(1);
      if (tcnt_d == TMAX) begin
        fault_d   = 1'b1;
        estado_d  = ST_NORMAL;
        pending_d = ST_NORMAL;
        cnt_d     = '0;
        changed_d = (estado_q != ST_NORMAL);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= ST_NORMAL;
      pending_q <= ST_NORMAL;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      changed_q <= changed_d;
      fault_q   <= fault_d;
    end
  end

  assign estado        = estado_q;
  assign state_changed = changed_q;
  assign sensor_fault  = fault_q;

endmodule
